// File: rtl/api_pkg.sv
// Shared constants and bus FSM state type for the miner controller API slave.
package api_pkg;

    localparam logic [5:0] API_TXFIFO  = 6'h00;
    localparam logic [5:0] API_RXFIFO  = 6'h04;
    localparam logic [5:0] API_STATE   = 6'h08;
    localparam logic [5:0] API_TIMEOUT = 6'h0C;
    localparam logic [5:0] API_SCK     = 6'h10;
    localparam logic [5:0] API_LW      = 6'h18;

    localparam logic [31:0] RX_EMPTY_MAGIC = 32'h1234_5678;
    localparam logic [31:0] BAD_ADDR_MAGIC = 32'hDEAD_DEAD;
    localparam logic [31:0] NONCE_FILLER   = 32'hBEAF_BEAF;

    localparam logic [2:0] FLUSH_CYCLES = 3'd4;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_WAIT_TX,
        BUS_RESP
    } bus_state_e;

endpackage

// File: rtl/lw_counter_bank.sv
// Per-miner local-work counters with sticky saturation and snapshot-and-clear.
module lw_counter_bank #(
    parameter int NUM_MINERS = 10,
    parameter int CNT_W      = 24,
    parameter int MID_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic [MID_W-1:0] inc_id,
    input  logic             clr_en,
    input  logic [3:0]       clr_idx,
    output logic [CNT_W-1:0] sel_cnt,
    output logic             sel_sat
);

    logic [CNT_W-1:0]      cnt_q [NUM_MINERS];
    logic [CNT_W-1:0]      cnt_d [NUM_MINERS];
    logic [NUM_MINERS-1:0] sat_q, sat_d;

    always_comb begin
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        sel_cnt = '0;
        sel_sat = 1'b0;
        for (int i = 0; i < NUM_MINERS; i++) begin
            // A clear that coincides with an increment keeps that one new count.
            if (clr_en && (32'(clr_idx) == i)) begin
                sel_cnt  = cnt_q[i];
                sel_sat  = sat_q[i];
                cnt_d[i] = (inc_en && (32'(inc_id) == i)) ? CNT_W'(1) : '0;
                sat_d[i] = 1'b0;
            end else if (inc_en && (32'(inc_id) == i)) begin
                if (&cnt_q[i]) sat_d[i] = 1'b1;
                else           cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: the counter array is software-visible state, so every entry gets reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_MINERS; i++) cnt_q[i] <= '0;
            sat_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

endmodule

// File: rtl/api_slave_mc.sv
// Wishbone register slave for the miner controller: FIFO access, configuration
// registers, and per-miner local-work counters.
module api_slave_mc
    import api_pkg::*;
#(
    parameter int NUM_MINERS = 10,
    parameter int CNT_W      = 24,
    parameter int MID_W      = 4,
    parameter int WIN_LO     = 2,
    parameter int WIN_HI     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             API_CYC_I,
    input  logic             API_STB_I,
    input  logic             API_WE_I,
    input  logic [5:0]       API_ADR_I,
    input  logic [31:0]      API_DAT_I,
    output logic             API_ACK_O,
    output logic             API_ERR_O,
    output logic [31:0]      API_DAT_O,
    output logic             txfifo_push,
    output logic [31:0]      txfifo_din,
    input  logic             txfull,
    input  logic [10:0]      txcnt,
    output logic             rxfifo_pop,
    input  logic [31:0]      rxfifo_dout,
    input  logic             rxempty,
    input  logic [9:0]       rxcnt,
    input  logic [2:0]       reg_state,
    output logic             reg_flush,
    output logic [27:0]      reg_timeout,
    output logic [7:0]       reg_sck,
    output logic [5:0]       reg_ch_num,
    output logic [7:0]       reg_word_num,
    input  logic             rx_fifo_wr_en,
    input  logic [31:0]      rx_fifo_din,
    input  logic [MID_W-1:0] miner_id,
    input  logic [4:0]       work_cnt
);

    bus_state_e       state_q, state_d;
    logic             ack_q, ack_d, err_q, err_d;
    logic [31:0]      dat_q, dat_d;
    logic [27:0]      timeout_q, timeout_d;
    logic [7:0]       sck_q, sck_d, word_num_q, word_num_d;
    logic [5:0]       ch_num_q, ch_num_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic             snap_sat_q, snap_sat_d;
    logic [31:0]      last_win_q, last_win_d;

    logic             access, lw_clr, in_win, nonce_ok;
    logic [CNT_W-1:0] bank_cnt;
    logic             bank_sat;
    logic [31:0]      lw_rd;

    // The dedup word tracks every in-window write, counted or not.
    assign in_win   = rx_fifo_wr_en && (32'(work_cnt) >= WIN_LO) && (32'(work_cnt) <= WIN_HI);
    assign nonce_ok = in_win && (rx_fifo_din != NONCE_FILLER) && (rx_fifo_din != 32'h0)
                      && (rx_fifo_din != 32'hFFFF_FFFF) && (rx_fifo_din != last_win_q);
    assign last_win_d = in_win ? rx_fifo_din : last_win_q;

    always_comb begin
        lw_rd            = '0;
        lw_rd[CNT_W-1:0] = snap_q;
        lw_rd[31]        = snap_sat_q;
    end

    // NOTE: every signal assigned below gets a default first, so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        dat_d       = '0;
        timeout_d   = timeout_q;
        sck_d       = sck_q;
        ch_num_d    = ch_num_q;
        word_num_d  = word_num_q;
        flush_cnt_d = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
        snap_d      = snap_q;
        snap_sat_d  = snap_sat_q;
        access      = 1'b0;
        txfifo_push = 1'b0;
        rxfifo_pop  = 1'b0;
        lw_clr      = 1'b0;

        case (state_q)
            BUS_IDLE:
                if (API_CYC_I && API_STB_I) begin
                    if (API_ADR_I == API_TXFIFO && API_WE_I && txfull) begin
                        state_d = BUS_WAIT_TX;
                    end else begin
                        state_d = BUS_RESP;
                        access  = 1'b1;
                    end
                end
            BUS_WAIT_TX:
                if (!(API_CYC_I && API_STB_I)) begin
                    state_d = BUS_IDLE;
                end else if (!txfull) begin
                    state_d = BUS_RESP;
                    access  = 1'b1;
                end
            default: state_d = BUS_IDLE;
        endcase

        // Side effects fire only on the single cycle the FSM commits the access.
        if (access) begin
            ack_d = 1'b1;
            case (API_ADR_I)
                API_TXFIFO:
                    if (API_WE_I) txfifo_push = 1'b1;
                    else          dat_d = {21'b0, txcnt};
                API_RXFIFO:
                    if (API_WE_I) begin
                        ack_d = 1'b0;
                        err_d = 1'b1;
                        dat_d = BAD_ADDR_MAGIC;
                    end else if (rxempty) begin
                        dat_d = RX_EMPTY_MAGIC;
                    end else begin
                        dat_d      = rxfifo_dout;
                        rxfifo_pop = 1'b1;
                    end
                API_STATE:
                    if (API_WE_I) begin
                        if (API_DAT_I[1]) flush_cnt_d = FLUSH_CYCLES;
                    end else begin
                        dat_d = {2'b0, rxcnt, 3'b0, rxempty, reg_state, txcnt, reg_flush, txfull};
                    end
                API_TIMEOUT:
                    if (API_WE_I) timeout_d = API_DAT_I[27:0];
                    else          dat_d = {4'b0, timeout_q};
                API_SCK:
                    if (API_WE_I) begin
                        sck_d      = API_DAT_I[7:0];
                        ch_num_d   = API_DAT_I[21:16];
                        word_num_d = API_DAT_I[31:24];
                    end else begin
                        dat_d = {word_num_q, 2'b0, ch_num_q, 8'b0, sck_q};
                    end
                API_LW:
                    if (!API_WE_I) begin
                        dat_d = lw_rd;
                    end else if (32'(API_DAT_I[3:0]) < NUM_MINERS) begin
                        lw_clr     = 1'b1;
                        snap_d     = bank_cnt;
                        snap_sat_d = bank_sat;
                    end else begin
                        ack_d = 1'b0;
                        err_d = 1'b1;
                        dat_d = BAD_ADDR_MAGIC;
                    end
                default: begin
                    ack_d = 1'b0;
                    err_d = 1'b1;
                    dat_d = BAD_ADDR_MAGIC;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BUS_IDLE;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            timeout_q   <= '0;
            sck_q       <= '0;
            ch_num_q    <= '0;
            word_num_q  <= '0;
            flush_cnt_q <= '0;
            snap_q      <= '0;
            snap_sat_q  <= 1'b0;
            last_win_q  <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            dat_q       <= dat_d;
            timeout_q   <= timeout_d;
            sck_q       <= sck_d;
            ch_num_q    <= ch_num_d;
            word_num_q  <= word_num_d;
            flush_cnt_q <= flush_cnt_d;
            snap_q      <= snap_d;
            snap_sat_q  <= snap_sat_d;
            last_win_q  <= last_win_d;
        end
    end

    lw_counter_bank #(
        .NUM_MINERS(NUM_MINERS),
        .CNT_W     (CNT_W),
        .MID_W     (MID_W)
    ) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (nonce_ok),
        .inc_id (miner_id),
        .clr_en (lw_clr),
        .clr_idx(API_DAT_I[3:0]),
        .sel_cnt(bank_cnt),
        .sel_sat(bank_sat)
    );

    assign API_ACK_O    = ack_q;
    assign API_ERR_O    = err_q;
    assign API_DAT_O    = dat_q;
    assign txfifo_din   = txfifo_push ? API_DAT_I : 32'h0;
    assign reg_flush    = (flush_cnt_q != 3'd0);
    assign reg_timeout  = timeout_q;
    assign reg_sck      = sck_q;
    assign reg_ch_num   = ch_num_q;
    assign reg_word_num = word_num_q;

endmodule

// File: tb/tb_api_slave_mc.sv
// Directed self-checking bench for api_slave_mc (NUM_MINERS=10, CNT_W=8).
module tb_api_slave_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [5:0]  adr = '0;
    logic [31:0] dat_i = '0;
    logic        ack, err;
    logic [31:0] dat_o;
    logic        txfifo_push, rxfifo_pop, reg_flush;
    logic [31:0] txfifo_din;
    logic        txfull = 1'b0, rxempty = 1'b1;
    logic [10:0] txcnt = '0;
    logic [31:0] rxfifo_dout = '0;
    logic [9:0]  rxcnt = '0;
    logic [2:0]  reg_state = '0;
    logic [27:0] reg_timeout;
    logic [7:0]  reg_sck, reg_word_num;
    logic [5:0]  reg_ch_num;
    logic        nonce_wr = 1'b0;
    logic [31:0] nonce = '0;
    logic [3:0]  mid = '0;
    logic [4:0]  wcnt = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    api_slave_mc #(.NUM_MINERS(10), .CNT_W(8), .MID_W(4), .WIN_LO(2), .WIN_HI(9)) dut (
        .clk(clk), .rst_n(rst_n),
        .API_CYC_I(cyc), .API_STB_I(stb), .API_WE_I(we), .API_ADR_I(adr), .API_DAT_I(dat_i),
        .API_ACK_O(ack), .API_ERR_O(err), .API_DAT_O(dat_o),
        .txfifo_push(txfifo_push), .txfifo_din(txfifo_din), .txfull(txfull), .txcnt(txcnt),
        .rxfifo_pop(rxfifo_pop), .rxfifo_dout(rxfifo_dout), .rxempty(rxempty), .rxcnt(rxcnt),
        .reg_state(reg_state), .reg_flush(reg_flush), .reg_timeout(reg_timeout),
        .reg_sck(reg_sck), .reg_ch_num(reg_ch_num), .reg_word_num(reg_word_num),
        .rx_fifo_wr_en(nonce_wr), .rx_fifo_din(nonce), .miner_id(mid), .work_cnt(wcnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one bus transaction; starts and ends one time unit after a rising edge.
    task automatic xfer(input logic [5:0] a, input logic w, input logic [31:0] d,
                        output logic [1:0] resp, output logic [31:0] rdat,
                        output int pushes, output int pops);
        logic done = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        resp = 2'b00; rdat = '0; pushes = 0; pops = 0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (txfifo_push) pushes++;
            if (rxfifo_pop) pops++;
            if (ack || err) begin
                resp = {ack, err};
                rdat = dat_o;
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("bus_terminated", 32'(done), 32'd1);
    endtask

    task automatic wr(input string tag, input logic [5:0] a, input logic [31:0] d,
                      input logic [1:0] exp_resp);
        logic [1:0] r; logic [31:0] q; int np, nq;
        xfer(a, 1'b1, d, r, q, np, nq);
        check({tag, "_resp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp,
                      input logic [1:0] exp_resp);
        logic [1:0] r; logic [31:0] q; int np, nq;
        xfer(a, 1'b0, 32'h0, r, q, np, nq);
        check({tag, "_resp"}, 32'(r), 32'(exp_resp));
        check({tag, "_data"}, q, exp);
    endtask

    task automatic feed(input logic [3:0] m, input logic [4:0] wc, input logic [31:0] d);
        mid = m; wcnt = wc; nonce = d; nonce_wr = 1'b1;
        @(posedge clk); #1;
        nonce_wr = 1'b0;
    endtask

    initial begin : stim
        logic [1:0]  r;
        logic [31:0] q;
        int          np, nq, acc_ack, acc_push;

        // Reset state
        #3 rst_n = 1'b0;
        #20;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_flush", 32'(reg_flush), 32'd0);
        check("rst_timeout", 32'(reg_timeout), 32'h0);
        check("rst_sck", {reg_word_num, 2'b0, reg_ch_num, 8'b0, reg_sck}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // TX write stalled by txfull
        txfull = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 6'h00; dat_i = 32'hA5A5_A5A5;
        acc_ack = 0; acc_push = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc_ack  += int'(ack || err);
            acc_push += int'(txfifo_push);
        end
        check("stall_no_ack", 32'(acc_ack), 32'd0);
        check("stall_no_push", 32'(acc_push), 32'd0);
        @(posedge clk); #1 txfull = 1'b0;
        @(negedge clk);
        check("tx_push", 32'(txfifo_push), 32'd1);
        check("tx_din", txfifo_din, 32'hA5A5_A5A5);
        check("tx_ack_not_yet", 32'(ack), 32'd0);
        @(negedge clk);
        check("tx_push_once", 32'(txfifo_push), 32'd0);
        check("tx_ack", {30'b0, ack, err}, 32'd2);
        @(posedge clk); #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;

        // Master abandons a stalled TX write
        txfull = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 6'h00; dat_i = 32'h0BAD_0BAD;
        repeat (2) @(posedge clk);
        #1 cyc = 1'b0; stb = 1'b0; we = 1'b0; txfull = 1'b0;
        acc_ack = 0; acc_push = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acc_ack  += int'(ack || err);
            acc_push += int'(txfifo_push);
        end
        check("abort_no_push", 32'(acc_push), 32'd0);
        check("abort_no_ack", 32'(acc_ack), 32'd0);
        @(posedge clk); #1;

        // TX fill level read
        txcnt = 11'h123;
        rd("tx_read", 6'h00, 32'h0000_0123, 2'b10);

        // RX reads: empty returns the magic word, non-empty pops exactly once
        rxempty = 1'b1;
        xfer(6'h04, 1'b0, 32'h0, r, q, np, nq);
        check("rx_empty_data", q, 32'h1234_5678);
        check("rx_empty_pops", 32'(nq), 32'd0);
        rxempty = 1'b0; rxfifo_dout = 32'h1122_3344;
        xfer(6'h04, 1'b0, 32'h0, r, q, np, nq);
        check("rx_data", q, 32'h1122_3344);
        check("rx_pops", 32'(nq), 32'd1);
        wr("rx_write_err", 6'h04, 32'h1, 2'b01);

        // Configuration registers
        wr("timeout_wr", 6'h0C, 32'hFFFF_FFFF, 2'b10);
        check("timeout_port", 32'(reg_timeout), 32'h0FFF_FFFF);
        rd("timeout_rd", 6'h0C, 32'h0FFF_FFFF, 2'b10);
        wr("sck_wr", 6'h10, 32'h1234_5678, 2'b10);
        check("sck_ports", {reg_word_num, 2'b0, reg_ch_num, 8'b0, reg_sck}, 32'h1234_0078);
        rd("sck_rd", 6'h10, 32'h1234_0078, 2'b10);

        // STATE read packing
        rxcnt = 10'h2A5; rxempty = 1'b1; reg_state = 3'b101;
        rd("state_rd", 6'h08, 32'h2A51_A48C, 2'b10);

        // Local-work counting for miner 3: five distinct qualified words
        feed(4'd3, 5'd5, 32'h0000_1001);
        feed(4'd3, 5'd5, 32'h0000_1002);
        feed(4'd3, 5'd5, 32'h0000_1002);
        feed(4'd3, 5'd5, 32'h0000_1003);
        feed(4'd3, 5'd2, 32'hBEAF_BEAF);
        feed(4'd3, 5'd9, 32'h0000_1004);
        feed(4'd3, 5'd10, 32'h0000_2000);
        feed(4'd3, 5'd1, 32'h0000_2001);
        feed(4'd3, 5'd4, 32'h0000_0000);
        feed(4'd3, 5'd4, 32'hFFFF_FFFF);
        feed(4'd3, 5'd4, 32'h0000_1005);
        feed(4'd12, 5'd4, 32'h0000_C001);
        feed(4'd5, 5'd4, 32'h0000_5001);
        wr("lw_snap3", 6'h18, 32'h3, 2'b10);
        rd("lw_cnt3", 6'h18, 32'h0000_0005, 2'b10);

        // Error terminations leave state untouched
        rd("bad_addr", 6'h3C, 32'hDEAD_DEAD, 2'b01);
        xfer(6'h18, 1'b1, 32'hC, r, q, np, nq);
        check("lw_bad_idx_resp", 32'(r), 32'd1);
        check("lw_bad_idx_data", q, 32'hDEAD_DEAD);
        rd("lw_after_bad", 6'h18, 32'h0000_0005, 2'b10);
        wr("lw_snap5", 6'h18, 32'h5, 2'b10);
        rd("lw_cnt5", 6'h18, 32'h0000_0001, 2'b10);
        wr("lw_resnap3", 6'h18, 32'h3, 2'b10);
        rd("lw_cnt3_cleared", 6'h18, 32'h0000_0000, 2'b10);

        // Saturation of an 8-bit counter
        for (int i = 0; i < 300; i++) feed(4'd0, 5'd3, 32'h0001_0000 + 32'(i));
        wr("lw_snap0", 6'h18, 32'h0, 2'b10);
        rd("lw_sat0", 6'h18, 32'h8000_00FF, 2'b10);

        // Increment coinciding with the clear of the same counter
        feed(4'd7, 5'd3, 32'h0000_7001);
        feed(4'd7, 5'd3, 32'h0000_7002);
        mid = 4'd7; wcnt = 5'd3; nonce = 32'h0000_7003; nonce_wr = 1'b1;
        wr("lw_snap7", 6'h18, 32'h7, 2'b10);
        nonce_wr = 1'b0;
        rd("lw_cnt7", 6'h18, 32'h0000_0002, 2'b10);
        wr("lw_resnap7", 6'h18, 32'h7, 2'b10);
        rd("lw_cnt7_coincident", 6'h18, 32'h0000_0001, 2'b10);

        // Flush pulse: bit 1 clear does nothing, bit 1 set gives four cycles
        wr("state_wr_noflush", 6'h08, 32'h1, 2'b10);
        check("noflush", 32'(reg_flush), 32'd0);
        wr("state_wr_flush", 6'h08, 32'h2, 2'b10);
        acc_push = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acc_push += int'(reg_flush);
        end
        check("flush_remaining", 32'(acc_push), 32'd3);
        @(posedge clk); #1;

        // Reset during the second flush cycle
        feed(4'd9, 5'd3, 32'h0000_9009);
        wr("state_wr_flush2", 6'h08, 32'h2, 2'b10);
        check("flush_second_cycle", 32'(reg_flush), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_flush_drop", 32'(reg_flush), 32'd0);
        check("rst_timeout2", 32'(reg_timeout), 32'h0);
        check("rst_sck2", {reg_word_num, 2'b0, reg_ch_num, 8'b0, reg_sck}, 32'h0);
        check("rst_dat2", dat_o, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        rd("lw_snap_after_rst", 6'h18, 32'h0000_0000, 2'b10);
        feed(4'd9, 5'd3, 32'h0000_9009);
        wr("lw_snap9", 6'h18, 32'h9, 2'b10);
        rd("lw_cnt9_after_rst", 6'h18, 32'h0000_0001, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
